// File: rtl/sat_ctrl_pkg.sv
// sat_ctrl_pkg
//   Shared types and widths for the SAT controller blocks.
//   - MAX_VAR_BITS      : width of a variable id
//   - CLAUSE_TABLE_BITS : width of a clause-table index
//   - walk_state_t      : states of the clause walk sequencer
// Widths come from the system-wide MAX_VAR_BITS / CLAUSE_TABLE_BITS macros.
// Defaults apply when no system definition is in scope.
`ifndef MAX_VAR_BITS
`define MAX_VAR_BITS 4
`endif
`ifndef CLAUSE_TABLE_BITS
`define CLAUSE_TABLE_BITS 6
`endif

package sat_ctrl_pkg;

    localparam int MAX_VAR_BITS      = `MAX_VAR_BITS;
    localparam int CLAUSE_TABLE_BITS = `CLAUSE_TABLE_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } walk_state_t;

endpackage

// File: rtl/clause_walk_ctrl.sv
// clause_walk_ctrl
//   Sole master of the per-variable start/end clause table. Accepts a walk
//   request for a variable, reads its [start,end) range and streams every
//   clause index in that range downstream over a valid/ready handshake.
//   Loader configuration writes are arbitrated against walks and win in IDLE.
// Ports:
//   clock, reset_n                 : clock, synchronous active-low reset
//   var_valid/var_ready/var_id     : walk request handshake
//   cfg_write/cfg_ready/cfg_var,
//   cfg_start/cfg_end              : loader table-write handshake
//   tbl_read/tbl_write/tbl_var,
//   tbl_start_wr/tbl_end_wr        : table control and write data
//   tbl_start_rd/tbl_end_rd        : table read data (combinational)
//   cl_valid/cl_ready/cl_idx,
//   cl_var/cl_last                 : clause index stream
//   abort                          : cancel the walk in progress
//   busy, done, done_count         : status; done_count valid with done
module clause_walk_ctrl
    import sat_ctrl_pkg::*;
#(
    parameter int VAR_BITS = MAX_VAR_BITS,
    parameter int TBL_BITS = CLAUSE_TABLE_BITS
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                var_valid,
    output logic                var_ready,
    input  logic [VAR_BITS-1:0] var_id,
    input  logic                cfg_write,
    output logic                cfg_ready,
    input  logic [VAR_BITS-1:0] cfg_var,
    input  logic [TBL_BITS-1:0] cfg_start,
    input  logic [TBL_BITS-1:0] cfg_end,
    output logic                tbl_read,
    output logic                tbl_write,
    output logic [VAR_BITS-1:0] tbl_var,
    output logic [TBL_BITS-1:0] tbl_start_wr,
    output logic [TBL_BITS-1:0] tbl_end_wr,
    input  logic [TBL_BITS-1:0] tbl_start_rd,
    input  logic [TBL_BITS-1:0] tbl_end_rd,
    output logic                cl_valid,
    input  logic                cl_ready,
    output logic [TBL_BITS-1:0] cl_idx,
    output logic [VAR_BITS-1:0] cl_var,
    output logic                cl_last,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [TBL_BITS-1:0] done_count
);

    walk_state_t         state;
    walk_state_t         next_state;
    logic [TBL_BITS-1:0] cur;
    logic [TBL_BITS-1:0] end_r;
    logic [VAR_BITS-1:0] var_r;
    logic [TBL_BITS-1:0] count;
    logic [TBL_BITS:0]   cur_inc;
    logic                is_last;

    // One extra bit so an end of 2**TBL_BITS-1 plus one cannot wrap to zero.
    assign cur_inc = {1'b0, cur} + {{TBL_BITS{1'b0}}, 1'b1};
    assign is_last = (cur_inc == {1'b0, end_r});

    // Every output is forced low while reset_n is asserted, including the
    // ready signals, so nothing upstream can handshake during reset.
    always_comb begin
        next_state   = state;
        var_ready    = 1'b0;
        cfg_ready    = 1'b0;
        tbl_read     = 1'b0;
        tbl_write    = 1'b0;
        tbl_var      = '0;
        tbl_start_wr = '0;
        tbl_end_wr   = '0;
        cl_valid     = 1'b0;
        cl_idx       = '0;
        cl_var       = '0;
        cl_last      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        done_count   = '0;
        if (reset_n) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    cfg_ready = 1'b1;
                    // Loader writes take priority over walk requests.
                    var_ready = !cfg_write;
                    if (cfg_write) begin
                        tbl_write    = 1'b1;
                        tbl_var      = cfg_var;
                        tbl_start_wr = cfg_start;
                        tbl_end_wr   = cfg_end;
                    end else if (var_valid) begin
                        next_state = LOOKUP;
                    end
                end
                LOOKUP: begin
                    tbl_read = 1'b1;
                    tbl_var  = var_r;
                    if (abort)
                        next_state = IDLE;
                    else if (tbl_start_rd >= tbl_end_rd)
                        next_state = DONE;
                    else
                        next_state = ISSUE;
                end
                ISSUE: begin
                    cl_valid = 1'b1;
                    cl_idx   = cur;
                    cl_var   = var_r;
                    cl_last  = is_last;
                    if (abort)
                        next_state = IDLE;
                    else if (cl_ready && is_last)
                        next_state = DONE;
                end
                DONE: begin
                    // The pulse is still produced if abort arrives here.
                    done       = 1'b1;
                    done_count = count;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            cur   <= '0;
            end_r <= '0;
            var_r <= '0;
            count <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (var_valid && !cfg_write)
                        var_r <= var_id;
                end
                LOOKUP: begin
                    cur   <= tbl_start_rd;
                    end_r <= tbl_end_rd;
                    count <= '0;
                end
                ISSUE: begin
                    // A handshake coinciding with abort still counts.
                    if (cl_ready) begin
                        cur   <= cur_inc[TBL_BITS-1:0];
                        count <= count + TBL_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clause_walk_ctrl.sv
module tb_clause_walk_ctrl;
    import sat_ctrl_pkg::*;

    localparam int VB = MAX_VAR_BITS;
    localparam int TB = CLAUSE_TABLE_BITS;
    localparam int NV = 1 << VB;

    logic          clock;
    logic          reset_n;
    logic          var_valid;
    logic          var_ready;
    logic [VB-1:0] var_id;
    logic          cfg_write;
    logic          cfg_ready;
    logic [VB-1:0] cfg_var;
    logic [TB-1:0] cfg_start;
    logic [TB-1:0] cfg_end;
    logic          tbl_read;
    logic          tbl_write;
    logic [VB-1:0] tbl_var;
    logic [TB-1:0] tbl_start_wr;
    logic [TB-1:0] tbl_end_wr;
    logic [TB-1:0] tbl_start_rd;
    logic [TB-1:0] tbl_end_rd;
    logic          cl_valid;
    logic          cl_ready;
    logic [TB-1:0] cl_idx;
    logic [VB-1:0] cl_var;
    logic          cl_last;
    logic          abort;
    logic          busy;
    logic          done;
    logic [TB-1:0] done_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [TB-1:0] idx;
        logic [VB-1:0] v;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];

    // Start/end table that sits beside the controller.
    logic [TB-1:0] ts [NV];
    logic [TB-1:0] te [NV];
    // Bench's own record of what the loader configured.
    int ms [NV];
    int me [NV];

    always @(posedge clock)
        if (tbl_write) begin
            ts[tbl_var] <= tbl_start_wr;
            te[tbl_var] <= tbl_end_wr;
        end
    assign tbl_start_rd = ts[tbl_var];
    assign tbl_end_rd   = te[tbl_var];

    clause_walk_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .var_valid(var_valid), .var_ready(var_ready), .var_id(var_id),
        .cfg_write(cfg_write), .cfg_ready(cfg_ready), .cfg_var(cfg_var),
        .cfg_start(cfg_start), .cfg_end(cfg_end),
        .tbl_read(tbl_read), .tbl_write(tbl_write), .tbl_var(tbl_var),
        .tbl_start_wr(tbl_start_wr), .tbl_end_wr(tbl_end_wr),
        .tbl_start_rd(tbl_start_rd), .tbl_end_rd(tbl_end_rd),
        .cl_valid(cl_valid), .cl_ready(cl_ready), .cl_idx(cl_idx),
        .cl_var(cl_var), .cl_last(cl_last), .abort(abort),
        .busy(busy), .done(done), .done_count(done_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    wire [63:0] all_outs = {var_ready, cfg_ready, tbl_read, tbl_write, tbl_var,
                            tbl_start_wr, tbl_end_wr, cl_valid, cl_idx, cl_var,
                            cl_last, busy, done, done_count};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every transferred index and every done pulse must match
    // the next expected entry.
    always @(negedge clock) begin
        if (cl_valid && cl_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("cl_unexpected", {52'd0, cl_idx}, 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("cl_idx", cl_idx, e.idx);
                check_eq("cl_var", cl_var, e.v);
                check_eq("cl_last", cl_last, e.last);
            end
        end
        if (done) begin
            if (done_q.size() == 0)
                check_eq("done_unexpected", done, 0);
            else
                check_eq("done_count", done_count, done_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_walk(input int v);
        for (int i = ms[v]; i < me[v]; i++) begin
            exp_t e;
            e.idx  = TB'(i);
            e.v    = VB'(v);
            e.last = (i + 1 == me[v]);
            exp_q.push_back(e);
        end
        done_q.push_back((me[v] > ms[v]) ? me[v] - ms[v] : 0);
    endtask

    task automatic cfg(input int v, input int s, input int e);
        cfg_write = 1'b1;
        cfg_var   = VB'(v);
        cfg_start = TB'(s);
        cfg_end   = TB'(e);
        #1;
        check_eq("cfg_ready", cfg_ready, 1);
        check_eq("cfg_tbl_write", tbl_write, 1);
        ms[v] = s;
        me[v] = e;
        tick();
        cfg_write = 1'b0;
    endtask

    // Handshake happens at the end of cycle 0; returns inside cycle 1.
    task automatic walk_start(input int v, input bit push);
        var_valid = 1'b1;
        var_id    = VB'(v);
        #1;
        check_eq("var_ready", var_ready, 1);
        if (push) push_walk(v);
        tick();
        var_valid = 1'b0;
        #1;
        check_eq("lookup_rd", tbl_read, 1);
        check_eq("lookup_var", tbl_var, v);
    endtask

    task automatic wait_done(input int start_cyc, output int cyc);
        cyc = -1;
        for (int n = start_cyc; n < start_cyc + 40; n++) begin
            if (done) begin
                cyc = n;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int c;
        int pat [5];
        int pidx [5];
        pat  = '{1, 0, 0, 1, 1};
        pidx = '{5, 6, 6, 6, 7};
        for (int i = 0; i < NV; i++) begin
            ts[i] = '0; te[i] = '0; ms[i] = 0; me[i] = 0;
        end
        reset_n = 0; var_valid = 0; var_id = '0; cfg_write = 0;
        cfg_var = '0; cfg_start = '0; cfg_end = '0; cl_ready = 0; abort = 0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_outs", all_outs, 0);
        reset_n = 1;
        #1;
        check_eq("idle_var_ready", var_ready, 1);
        check_eq("idle_cfg_ready", cfg_ready, 1);
        check_eq("idle_busy", busy, 0);
        tick();

        // 1: var3 = [5,8), full throughput
        cfg(3, 5, 8);
        cl_ready = 1;
        walk_start(3, 1);
        wait_done(1, c);
        check_eq("t1_done_cyc", c, 5);
        check_eq("t1_done_count", done_count, 3);
        tick();

        // 2: empty range
        cfg(9, 4, 4);
        walk_start(9, 1);
        check_eq("t2_no_valid", cl_valid, 0);
        wait_done(1, c);
        check_eq("t2_done_cyc", c, 2);
        check_eq("t2_done_count", done_count, 0);
        tick();

        // 3: back-to-back walk with stalls
        walk_start(3, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            cl_ready = pat[k][0];
            #1;
            check_eq("t3_valid", cl_valid, 1);
            check_eq("t3_idx", cl_idx, pidx[k]);
        end
        tick();
        check_eq("t3_done", done, 1);
        check_eq("t3_done_count", done_count, 3);
        tick();

        // 4: cfg beats walk in IDLE; cfg refused during ISSUE
        cfg_write = 1; cfg_var = 5; cfg_start = 10; cfg_end = 12;
        var_valid = 1; var_id = 5;
        #1;
        check_eq("t4_cfg_ready", cfg_ready, 1);
        check_eq("t4_tbl_write", tbl_write, 1);
        check_eq("t4_tbl_var", tbl_var, 5);
        check_eq("t4_var_blocked", var_ready, 0);
        ms[5] = 10; me[5] = 12;
        tick();
        cfg_write = 0;
        #1;
        check_eq("t4_var_ready", var_ready, 1);
        push_walk(5);
        tick();
        var_valid = 0;
        tick();
        cfg_write = 1; cfg_var = 2; cfg_start = 1; cfg_end = 3;
        #1;
        check_eq("t4_issue_cfg_ready", cfg_ready, 0);
        check_eq("t4_issue_tbl_write", tbl_write, 0);
        check_eq("t4_issue_valid", cl_valid, 1);
        cfg_write = 0;
        wait_done(2, c);
        check_eq("t4_done_cyc", c, 4);
        tick();
        walk_start(2, 1);
        wait_done(1, c);
        check_eq("t4_var2_untouched", c, 2);
        tick();

        // 5: abort on the handshake of index 6
        exp_q.push_back('{idx: 5, v: 3, last: 0});
        exp_q.push_back('{idx: 6, v: 3, last: 0});
        walk_start(3, 0);
        tick();
        tick();
        abort = 1;
        #1;
        check_eq("t5_idx", cl_idx, 6);
        tick();
        abort = 0;
        #1;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_done", done, 0);
        check_eq("t5_var_ready", var_ready, 1);
        repeat (4) tick();
        check_eq("t5_sb_empty", exp_q.size(), 0);

        // 6: reset mid-walk
        cl_ready = 0;
        walk_start(3, 0);
        tick();
        check_eq("t6_in_issue", cl_valid, 1);
        reset_n = 0;
        tick();
        check_eq("t6_rst_outs", all_outs, 0);
        check_eq("t6_rst_busy", busy, 0);
        reset_n = 1;
        #1;
        check_eq("t6_idle", busy, 0);
        exp_q.delete();
        done_q.delete();
        cl_ready = 1;
        walk_start(3, 1);
        wait_done(1, c);
        check_eq("t6_done_cyc", c, 5);
        check_eq("t6_done_count", done_count, 3);
        repeat (3) tick();

        check_eq("sb_idx_empty", exp_q.size(), 0);
        check_eq("sb_done_empty", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clause_walk_ctrl.md
Name: clause_walk_ctrl

Overview:
Sequencer in front of the per-variable start/end index table. On a request for a variable it reads that variable's clause-table range and streams every clause index in the range to the clause fetch stage using a valid/ready handshake. It is the only master of the table. It also arbitrates table configuration writes from the loader against walks.

Parameters:
VAR_BITS, `MAX_VAR_BITS, width of variable id
TBL_BITS, `CLAUSE_TABLE_BITS, width of clause-table index

Ports:
clock  in  1  sole clock
reset_n  in  1  synchronous, active-low reset
var_valid  in  1  walk request
var_ready  out  1  walk request accepted when var_valid&var_ready
var_id  in  VAR_BITS  variable to walk
cfg_write  in  1  loader write request
cfg_ready  out  1  loader write accepted when cfg_write&cfg_ready
cfg_var  in  VAR_BITS  entry to write
cfg_start  in  TBL_BITS  first clause index
cfg_end  in  TBL_BITS  one-past-last clause index (exclusive)
tbl_read  out  1  table read enable
tbl_write  out  1  table write enable
tbl_var  out  VAR_BITS  table var_in
tbl_start_wr  out  TBL_BITS  table start_in
tbl_end_wr  out  TBL_BITS  table end_in
tbl_start_rd  in  TBL_BITS  table start_out (combinational)
tbl_end_rd  in  TBL_BITS  table end_out (combinational)
cl_valid  out  1  clause index valid
cl_ready  in  1  downstream accepts index
cl_idx  out  TBL_BITS  clause index
cl_var  out  VAR_BITS  variable being walked
cl_last  out  1  final index of this walk
abort  in  1  cancel walk (conflict or backtrack)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at walk completion
done_count  out  TBL_BITS  indices issued; valid while done=1

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE. cur, end_r, var_r and count clear to 0. While reset_n=0, every output is 0, including var_ready and cfg_ready.
- States: IDLE, LOOKUP, ISSUE, DONE.
- IDLE: cfg_ready=1. var_ready=!cfg_write, so config has priority.
  - A cfg handshake drives tbl_write=1 combinationally with tbl_var=cfg_var, tbl_start_wr=cfg_start and tbl_end_wr=cfg_end. Stay in IDLE.
  - A var handshake latches var_r=var_id and moves to LOOKUP.
- LOOKUP (exactly 1 cycle): tbl_read=1, tbl_var=var_r. At the clock edge, latch cur=tbl_start_rd and end_r=tbl_end_rd, and clear count.
  - If tbl_start_rd >= tbl_end_rd, go to DONE. The range is empty, so no index is issued.
  - Otherwise go to ISSUE.
- ISSUE: cl_valid=1, cl_idx=cur, cl_var=var_r, cl_last=(cur+1 == end_r). The compare is done at TBL_BITS+1 width, so there is no wrap.
  - On cl_ready: cur+=1, count+=1. If cl_last, go to DONE.
  - Without cl_ready, outputs hold stable and cl_valid stays 1.
- DONE (1 cycle): done=1, done_count=count. Return to IDLE.
- Outside their states, tbl_read, tbl_write, cl_valid and done are 0. cfg_ready and var_ready are 0 whenever the state is not IDLE.
- abort in LOOKUP, ISSUE or DONE forces the next state to IDLE. In that case no done pulse is produced, except when abort arrives in DONE, where the done pulse of that cycle still occurs.
  - A cl handshake in the same cycle as abort still counts as transferred.
  - abort in IDLE is ignored.
- Latency: request accepted at cycle 0, LOOKUP at cycle 1, first cl_valid at cycle 2. With cl_ready held high, throughput is 1 index/cycle and done arrives at cycle 2+N for N indices. An empty range gives done at cycle 2.
- Back-to-back: a new walk can be accepted in the cycle after DONE.
- reset_n low mid-walk: state returns to IDLE on the next edge, and cl_valid and done are 0 from that cycle.

Decomposition:
- Shared package (sat_ctrl_pkg): walk_state_t enum {IDLE, LOOKUP, ISSUE, DONE}. Widths come from the sysdefs.svh macros.
- No sub-module: FSM, index counter and config mux are implemented inline.
- The testbench instantiates the start/end table alongside this block.

Test Plan:
1. Config var3=[5,8); walk var3, cl_ready=1 -> cl_idx 5,6,7 at cycles 2,3,4; cl_last only on 7; done at cycle 5 with done_count=3.
2. Config var9=[4,4); walk var9 -> no cl_valid; done at cycle 2 with done_count=0.
3. Walk var3 with cl_ready toggled 1,0,0,1,1 -> cl_idx holds 6 through the stall; sequence is 5,6,7 with no duplicates; done_count=3.
4. cfg_write and var_valid high together in IDLE -> cfg accepted first (tbl_write=1, var_ready=0); walk accepted next cycle. cfg_write during ISSUE -> cfg_ready=0 and tbl_write=0.
5. Walk var3; assert abort in the cycle cl_idx=6 handshakes -> IDLE next cycle; no done; var_ready=1 the cycle after.
6. Drive reset_n=0 during ISSUE -> next cycle all outputs are 0 and busy=0; a walk after release starts at LOOKUP normally.
